// File: rtl/pf_pkg.sv
// rtl/pf_pkg.sv - shared constants, state encoding and packing helper for norm_pf
package pf_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 28;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] signed_zero(input logic sign);
        return {sign, 31'b0};
    endfunction

endpackage

// File: rtl/rne_round.sv
// rtl/rne_round.sv - combinational round-to-nearest-even on a normalized mantissa
import pf_pkg::*;

module rne_round (
    input  logic [MANT_W-1:0] mant_i,
    input  logic [EXP_W:0]    exp_i,
    output logic [MANT_W-1:0] mant_o,
    output logic [EXP_W:0]    exp_o,
    output logic              carry_o
);

    logic              inc;
    logic [FRAC_W+1:0] sum;

    // Guard set and (round, sticky or LSB) set: above half-ULP, or a tie with odd LSB.
    assign inc     = mant_i[2] & (mant_i[1] | mant_i[0] | mant_i[3]);
    assign sum     = {1'b0, mant_i[FRAC_W+3:3]} + {{(FRAC_W+1){1'b0}}, inc};
    assign carry_o = sum[FRAC_W+1];
    assign mant_o  = carry_o ? {1'b0, sum[FRAC_W+1:1], 3'b000}
                             : {1'b0, sum[FRAC_W:0],   3'b000};
    assign exp_o   = exp_i + {{EXP_W{1'b0}}, carry_o};

endmodule

// File: rtl/norm_pf.sv
// rtl/norm_pf.sv - post-add normalize, round and pack to IEEE-754 single precision
import pf_pkg::*;

module norm_pf (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W-1:0]    in_exp,
    input  logic [MANT_W-1:0]   in_mant,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         result,
    output logic                out_ovf,
    output logic                out_unf
);

    localparam logic [EXP_W:0] EXP_LIMIT = (EXP_W+1)'(EXP_MAX);
    localparam logic [EXP_W:0] EXP_ONE   = (EXP_W+1)'(1);

    state_e              state_q;
    logic                sign_q;
    logic [EXP_W:0]      exp_q;
    logic [MANT_W-1:0]   mant_q;
    logic [31:0]         result_q;
    logic                ovf_q;
    logic                unf_q;

    logic [MANT_W-1:0]   rnd_mant;
    logic [EXP_W:0]      rnd_exp;
    logic                rnd_carry;

    rne_round u_rne_round (
        .mant_i  (mant_q),
        .exp_i   (exp_q),
        .mant_o  (rnd_mant),
        .exp_o   (rnd_exp),
        .carry_o (rnd_carry)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q  <= in_sign;
                        exp_q   <= {1'b0, in_exp};
                        mant_q  <= in_mant;
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (mant_q == '0) begin
                        result_q <= signed_zero(sign_q);
                        ovf_q    <= 1'b0;
                        unf_q    <= 1'b0;
                        state_q  <= DONE;
                    end else if (exp_q == '0) begin
                        // Denormal range: flush rather than produce a subnormal.
                        result_q <= signed_zero(sign_q);
                        ovf_q    <= 1'b0;
                        unf_q    <= 1'b1;
                        state_q  <= DONE;
                    end else if (mant_q[MANT_W-1]) begin
                        mant_q  <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                        exp_q   <= exp_q + EXP_ONE;
                        state_q <= ROUND;
                    end else if (mant_q[MANT_W-2]) begin
                        state_q <= ROUND;
                    end else begin
                        mant_q <= {mant_q[MANT_W-2:0], 1'b0};
                        exp_q  <= exp_q - EXP_ONE;
                    end
                end
                ROUND: begin
                    mant_q <= rnd_mant;
                    exp_q  <= rnd_exp;
                    unf_q  <= 1'b0;
                    if (rnd_exp >= EXP_LIMIT) begin
                        result_q <= {sign_q, 8'hFF, {FRAC_W{1'b0}}};
                        ovf_q    <= 1'b1;
                    end else begin
                        result_q <= {sign_q, rnd_exp[EXP_W-1:0], rnd_mant[FRAC_W+2:3]};
                        ovf_q    <= 1'b0;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic unused_carry;
    assign unused_carry = rnd_carry;

endmodule

// File: tb/tb_norm_pf.sv
// tb/tb_norm_pf.sv - directed self-checking bench for norm_pf
module tb_norm_pf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        out_ovf;
    logic        out_unf;

    int n_tests;
    int n_fail;

    norm_pf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Accept one operand, wait for out_valid, check latency/result/flags, optionally hold
    // out_ready low for a few DONE cycles, then complete the handshake.
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] m, input logic [31:0] want,
                          input logic want_ovf, input logic want_unf,
                          input int want_lat, input int hold);
        int lat;
        logic [31:0] snap;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        if (want_lat >= 0) check_eq({tag, "_latency"}, lat, want_lat);
        check_eq({tag, "_result"}, result, want);
        check_eq({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, want_ovf});
        check_eq({tag, "_unf"}, {31'b0, out_unf}, {31'b0, want_unf});
        snap = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_result"}, result, snap);
            check_eq({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check_eq({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_released"}, {31'b0, out_valid}, 32'd0);
        check_eq({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("reset_result", result, 32'h0);
        check_eq("reset_ovf", {31'b0, out_ovf}, 32'd0);
        check_eq("reset_unf", {31'b0, out_unf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_in_ready", {31'b0, in_ready}, 32'd1);

        run_op("one",        1'b0, 8'd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 2, 0);
        run_op("carry_two",  1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 2, 0);
        run_op("overflow",   1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 2, 0);
        run_op("lshift3",    1'b0, 8'd130, 28'h0800000, 32'h3F800000, 1'b0, 1'b0, 5, 0);
        run_op("underflow",  1'b0, 8'd2,   28'h0000100, 32'h00000000, 1'b0, 1'b1, -1, 0);
        run_op("tie_even",   1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 2, 0);
        run_op("tie_odd",    1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 2, 0);
        run_op("zero_neg",   1'b1, 8'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 1, 0);
        run_op("exp0_flush", 1'b1, 8'd0,   28'h4000000, 32'h80000000, 1'b0, 1'b1, 1, 0);
        run_op("rnd_carry",  1'b1, 8'd127, 28'h7FFFFFC, 32'hC0000000, 1'b0, 1'b0, 2, 0);
        run_op("sticky_rs",  1'b0, 8'd127, 28'h8000009, 32'h40000001, 1'b0, 1'b0, 2, 0);
        run_op("backpress",  1'b0, 8'd128, 28'h4000000, 32'h40000000, 1'b0, 1'b0, 2, 3);

        // Reset in the middle of a left-shift sequence must discard the operation.
        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 8'd130;
        in_mant  = 28'h0800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midreset_valid", {31'b0, out_valid}, 32'd0);
        check_eq("midreset_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("midreset_no_output", seen, 32'd0);

        run_op("after_reset", 1'b0, 8'd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
